mmio_io_responder: RTL and testbench

- Memory-mapped I/O responder on the CPU's data-memory port; serves loads/stores whose address has `io_addr[31:28] == 4'h8`.
- Bridges the CPU to the on-chip UART via valid/ready byte interfaces.
- Buffers received bytes in a small FIFO and holds one outgoing byte.
- Provides cycle and retired-instruction counters.
- Read data is registered, giving the same 1-cycle load latency as the block RAMs, so the writeback path muxes it like dmem/bios data.

---
 rtl/mmio_io_responder.sv | 71 +++++++
 tb/tb_mmio_io_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_responder.sv
// mmio_io_responder: memory-mapped UART bridge with RX FIFO, TX holding register and cycle/instruction counters.
module mmio_io_responder #(
  parameter int RX_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_addr,
  input  logic        io_re,
  input  logic        io_we,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  input  logic        inst_retire,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  logic [7:0]  fifo [RX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [31:0] cycle_cnt, inst_cnt, rdata_next;
  logic [5:0]  off;
  logic sel, rd, wr, empty, full, push, pop, tx_load, clr;
  logic unused_bits;
  assign unused_bits = ^{io_addr[27:8], io_addr[1:0], io_wdata[31:8]};
  assign sel = io_addr[31:28] == 4'h8;
  assign off = io_addr[7:2];
  assign rd = sel && io_re;
  assign wr = sel && io_we;
  assign empty = count == '0;
  assign full = count == (AW+1)'(RX_FIFO_DEPTH);
  assign uart_rx_ready = !full && !rst;
  assign push = uart_rx_valid && uart_rx_ready;
  assign pop = rd && off == 6'h01 && !empty;
  // a write landing in the handshake cycle still sees the register full and is dropped
  assign tx_load = wr && off == 6'h02 && !uart_tx_valid;
  assign clr = wr && off == 6'h06;
  always_comb
    rdata_next = !rd ? '0 :
                 off == 6'h00 ? {30'b0, !empty, !uart_tx_valid} :
                 off == 6'h01 ? {24'b0, empty ? 8'h00 : fifo[rd_ptr]} :
                 off == 6'h04 ? cycle_cnt :
                 off == 6'h05 ? inst_cnt : '0;
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= uart_rx_data;
  always_ff @(posedge clk)
    if (rst) begin
      io_rdata      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      uart_tx_valid <= 1'b0;
      uart_tx_data  <= 8'h00;
      cycle_cnt     <= '0;
      inst_cnt      <= '0;
    end else begin
      io_rdata <= rdata_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (tx_load) begin
        uart_tx_valid <= 1'b1;
        uart_tx_data  <= io_wdata[7:0];
      end else if (uart_tx_valid && uart_tx_ready) uart_tx_valid <= 1'b0;
      cycle_cnt <= clr ? '0 : cycle_cnt + 32'd1;
      inst_cnt  <= clr ? '0 : inst_cnt + 32'(inst_retire);
    end
endmodule

// File: tb/tb_mmio_io_responder.sv
// tb_mmio_io_responder: scoreboard bench with a queue-based reference model plus directed reads.
module tb_mmio_io_responder;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 1;
  logic [31:0] io_addr = 0, io_wdata = 0, io_rdata;
  logic io_re = 0, io_we = 0, inst_retire = 0;
  logic [7:0] uart_tx_data, uart_rx_data = 0;
  logic uart_tx_valid, uart_tx_ready = 0, uart_rx_valid = 0, uart_rx_ready;
  int checks = 0, errors = 0;

  mmio_io_responder #(.RX_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_re(io_re), .io_we(io_we),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .inst_retire(inst_retire),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_data_defined;
    logic        rx_ready;
  } exp_t;

  exp_t sb[$];
  logic [7:0] mq[$];
  logic txp = 0;
  logic [7:0] txb = 0;
  logic [31:0] mcyc = 0, minst = 0, mr;
  logic [7:0] moff;
  logic msel_rd, msel_wr, old_p;
  int mn;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  // reference model: evaluates the register-map rules on every clock edge
  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      mq.delete();
      txp = 0;
      txb = 0;
      mcyc = 0;
      minst = 0;
      mr = 0;
      e.tx_data_defined = 1;
    end else begin
      msel_rd = io_addr[31:28] == 4'h8 && io_re;
      msel_wr = io_addr[31:28] == 4'h8 && io_we;
      moff = io_addr[7:0] & 8'hFC;
      mn = mq.size();
      mr = 0;
      if (msel_rd) begin
        if (moff == 8'h00) mr = {30'b0, mn > 0, !txp};
        else if (moff == 8'h04) mr = mn > 0 ? {24'b0, mq[0]} : 0;
        else if (moff == 8'h10) mr = mcyc;
        else if (moff == 8'h14) mr = minst;
      end
      if (msel_rd && moff == 8'h04 && mn > 0) void'(mq.pop_front());
      if (uart_rx_valid && mn < DEPTH) mq.push_back(uart_rx_data);
      old_p = txp;
      if (txp && uart_tx_ready) txp = 0;
      if (msel_wr && moff == 8'h08 && !old_p) begin
        txp = 1;
        txb = io_wdata[7:0];
      end
      if (msel_wr && moff == 8'h18) begin
        mcyc = 0;
        minst = 0;
      end else begin
        mcyc = mcyc + 1;
        minst = minst + {31'b0, inst_retire};
      end
      e.tx_data_defined = txp;
    end
    e.rdata = mr;
    e.tx_valid = txp;
    e.tx_data = txb;
    e.rx_ready = mq.size() < DEPTH && !rst;
    sb.push_back(e);
  end

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) check("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      check("sb_rdata", io_rdata, e.rdata);
      check("sb_tx_valid", {31'b0, uart_tx_valid}, {31'b0, e.tx_valid});
      if (e.tx_data_defined) check("sb_tx_data", {24'b0, uart_tx_data}, {24'b0, e.tx_data});
      check("sb_rx_ready", {31'b0, uart_rx_ready}, {31'b0, e.rx_ready});
    end
  end

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    io_re = 1;
    io_addr = a;
    @(negedge clk);
    io_re = 0;
    check(name, io_rdata, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    io_we = 1;
    io_addr = a;
    io_wdata = d;
    @(negedge clk);
    io_we = 0;
  endtask

  task automatic push_rx(input logic [7:0] b);
    uart_rx_valid = 1;
    uart_rx_data = b;
    @(negedge clk);
    uart_rx_valid = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (5) @(negedge clk);
    check("idle_tx_valid", {31'b0, uart_tx_valid}, 0);
    check("idle_rx_ready", {31'b0, uart_rx_ready}, 1);
    read_chk("status_idle", 32'h8000_0000, 32'h1);
    io_re = 1;
    io_addr = 32'h8000_0010;
    @(negedge clk);
    io_re = 0;
    // TX stall: second write must be dropped
    wr(32'h8000_0008, 32'h0000_01A5);
    wr(32'h8000_0008, 32'h0000_005A);
    read_chk("status_tx_busy", 32'h8000_0000, 32'h0);
    check("tx_data_stall", {24'b0, uart_tx_data}, 32'hA5);
    uart_tx_ready = 1;
    @(negedge clk);
    uart_tx_ready = 0;
    check("tx_valid_after", {31'b0, uart_tx_valid}, 0);
    read_chk("status_tx_free", 32'h8000_0000, 32'h1);
    // fill FIFO, offer one extra byte
    for (int i = 0; i < 8; i++) push_rx(8'h11 + 8'(i));
    check("rx_ready_full", {31'b0, uart_rx_ready}, 0);
    push_rx(8'h99);
    for (int i = 0; i < 8; i++) read_chk("fifo_order", 32'h8000_0004, 32'h11 + i);
    read_chk("fifo_empty_read", 32'h8000_0004, 0);
    read_chk("status_empty", 32'h8000_0000, 32'h1);
    // simultaneous push and pop
    push_rx(8'h44);
    uart_rx_valid = 1;
    uart_rx_data = 8'h33;
    read_chk("pushpop_old", 32'h8000_0004, 32'h44);
    uart_rx_valid = 0;
    read_chk("pushpop_new", 32'h8000_0004, 32'h33);
    // retire counting, clear, wrap
    for (int i = 0; i < 20; i++) begin
      inst_retire = i[0];
      @(negedge clk);
    end
    inst_retire = 0;
    read_chk("inst_cnt_10", 32'h8000_0014, 10);
    wr(32'h8000_0018, 32'hDEAD_BEEF);
    read_chk("inst_cnt_clr", 32'h8000_0014, 0);
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    force dut.inst_cnt = 32'hFFFF_FFFF;
    release dut.cycle_cnt;
    release dut.inst_cnt;
    mcyc = 32'hFFFF_FFFE;
    minst = 32'hFFFF_FFFF;
    inst_retire = 1;
    @(negedge clk);
    inst_retire = 0;
    read_chk("cyc_max", 32'h8000_0010, 32'hFFFF_FFFF);
    read_chk("cyc_wrap", 32'h8000_0010, 0);
    read_chk("inst_wrap", 32'h8000_0014, 0);
    // reset with pending TX and buffered RX
    wr(32'h8000_0008, 32'h77);
    for (int i = 0; i < 3; i++) push_rx(8'hC0 + 8'(i));
    io_re = 1;
    io_addr = 32'h8000_0010;
    rst = 1;
    @(negedge clk);
    io_re = 0;
    check("rst_tx_valid", {31'b0, uart_tx_valid}, 0);
    check("rst_tx_data", {24'b0, uart_tx_data}, 0);
    check("rst_rdata", io_rdata, 0);
    check("rst_rx_ready", {31'b0, uart_rx_ready}, 0);
    rst = 0;
    read_chk("status_post_rst", 32'h8000_0000, 32'h1);
    read_chk("fifo_post_rst", 32'h8000_0004, 0);
    push_rx(8'h5C);
    read_chk("unselected_read", 32'h4000_0004, 0);
    read_chk("no_pop_unselected", 32'h8000_0004, 32'h5C);
    // randomized traffic checked by the scoreboard
    for (int i = 0; i < 600; i++) begin
      io_addr = {($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h8, 20'($urandom),
                 8'($urandom_range(0, 8) * 4) | 8'($urandom_range(0, 3))};
      io_re = $urandom_range(0, 1);
      io_we = $urandom_range(0, 4) == 0;
      io_wdata = $urandom;
      inst_retire = $urandom_range(0, 1);
      uart_rx_valid = $urandom_range(0, 2) == 0;
      uart_rx_data = 8'($urandom);
      uart_tx_ready = $urandom_range(0, 3) == 0;
      rst = $urandom_range(0, 99) == 0;
      @(negedge clk);
    end
    {io_re, io_we, uart_rx_valid, rst} = 4'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
